// File: rtl/vram_arbiter_pkg.sv
// Shared constants for the VRAM arbiter: geometry of the VRAM and the
// 3-bit encodings of the arbiter FSM states.
package vram_arbiter_pkg;

    localparam int VRAM_ADDR_W = 9;
    localparam int VRAM_DATA_W = 32;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_VGA_RD  = 3'd1;
    localparam logic [2:0] ST_VGA_CAP = 3'd2;
    localparam logic [2:0] ST_CPU_RD  = 3'd3;
    localparam logic [2:0] ST_CPU_CAP = 3'd4;
    localparam logic [2:0] ST_CPU_WR  = 3'd5;

endpackage

// File: rtl/vram_arbiter_starve_cnt.sv
// Saturating starvation counter. Counts arbitration rounds that a waiting
// CPU request has lost; sat tells the arbiter the CPU must win next time.
module vram_arbiter_starve_cnt #(
    parameter int LIMIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count;

    // Clear has priority over increment; the count stops at LIMIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != LIMIT_V)) begin
            count <= count + 1'b1;
        end
    end

    assign sat = (count == LIMIT_V);

endmodule

// File: rtl/vram_arbiter.sv
// Arbiter sharing a single-port synchronous VRAM between VGA scan-out
// (priority, keeps vga_data loaded with the word at vga_addr) and a CPU
// req/ack port. A starvation counter bounds how long the CPU can wait.
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W       = VRAM_ADDR_W,
    parameter int DATA_W       = VRAM_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_dout
);

    logic [2:0]        state;
    logic [2:0]        next_state;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [ADDR_W-1:0] last_addr;
    logic              last_valid;

    logic in_idle;
    logic vga_pend;
    logic cpu_vis;
    logic starve_sat;
    logic vga_win;
    logic cpu_grant;

    // The displayed word is stale if never fetched or the scan address moved.
    assign vga_pend  = !last_valid || (vga_addr != last_addr);
    // Masking with cpu_ack keeps a held request from being granted twice.
    assign cpu_vis   = cpu_req && !cpu_ack;
    assign in_idle   = (state == ST_IDLE);
    assign vga_win   = vga_pend && !(cpu_vis && starve_sat);
    assign cpu_grant = !vga_win && cpu_vis;

    vram_arbiter_starve_cnt #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (in_idle && cpu_vis && vga_win),
        .clr   (!cpu_req || (in_idle && cpu_grant)),
        .sat   (starve_sat)
    );

    // Next-state selection; only IDLE arbitrates, the other states just sequence.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (vga_win) begin
                    next_state = ST_VGA_RD;
                end else if (cpu_vis) begin
                    next_state = cpu_we ? ST_CPU_WR : ST_CPU_RD;
                end
            end
            ST_VGA_RD:  next_state = ST_VGA_CAP;
            ST_VGA_CAP: next_state = ST_IDLE;
            ST_CPU_RD:  next_state = ST_CPU_CAP;
            ST_CPU_CAP: next_state = ST_IDLE;
            ST_CPU_WR:  next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Request latches, read-data capture, ack pulse and display-word tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_addr   <= '0;
            lat_wdata  <= '0;
            last_addr  <= '0;
            last_valid <= 1'b0;
            vga_data   <= '0;
            cpu_rdata  <= '0;
            cpu_ack    <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (vga_win) begin
                        lat_addr <= vga_addr;
                    end else if (cpu_vis) begin
                        lat_addr  <= cpu_addr;
                        lat_wdata <= cpu_wdata;
                    end
                end
                ST_VGA_CAP: begin
                    vga_data   <= ram_dout;
                    last_addr  <= lat_addr;
                    last_valid <= 1'b1;
                end
                ST_CPU_CAP: begin
                    cpu_rdata <= ram_dout;
                    cpu_ack   <= 1'b1;
                end
                ST_CPU_WR: begin
                    cpu_ack <= 1'b1;
                    if (lat_addr == last_addr) begin
                        last_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // VRAM port decode; idle whenever no access state is active, so reset drops it at once.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state)
            ST_VGA_RD, ST_CPU_RD: begin
                ram_en   = 1'b1;
                ram_addr = lat_addr;
            end
            ST_CPU_WR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = lat_addr;
                ram_wdata = lat_wdata;
            end
            default: begin
            end
        endcase
    end

endmodule
